// File: rtl/kalkulator_seq.sv
// Sequential board calculator: debounced keys start an add/subtract/multiply on
// the SW operands, and the result is converted to BCD and shown on HEX with sign and overflow.
module kalkulator_seq #(
  parameter int W          = 5,
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_N,
  input  logic [2:0]            KEY,
  input  logic [2*W-1:0]        SW,
  output logic [7*DIGITS-1:0]   HEX,
  output logic [2:0]            LEDR
);

  localparam int MW = 2 * W;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DEB_CYCLES + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_POS = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] MAX_NEG = pow10(DIGITS - 1) - 64'd1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [7*DIGITS-1:0] HEX_RST = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};
  localparam logic [MW-1:0] ITER_LAST = MW'(MW - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_LOAD} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Key path: keys idle high, so synchroniser and debounced levels reset to 1.
  logic [2:0]    r_sync1, r_sync2, r_deb, r_deb_d;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    w_pulse;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
      r_deb   <= 3'b111;
      r_deb_d <= 3'b111;
      for (int k = 0; k < 3; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int k = 0; k < 3; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CW'(DEB_CYCLES - 1)) begin
          r_deb[k] <= ~r_deb[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CW'(1);
        end
      end
    end
  end

  assign w_pulse = r_deb_d & ~r_deb;

  logic [1:0] w_op;
  always_comb begin
    w_op = OP_ADD;
    if (w_pulse[0])      w_op = OP_ADD;
    else if (w_pulse[1]) w_op = OP_SUB;
    else if (w_pulse[2]) w_op = OP_MUL;
  end

  state_t r_state, w_next;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  logic [W-1:0]  r_a, r_b;
  logic [1:0]    r_op;
  logic [MW-1:0] r_mag, r_iter;
  logic          r_neg, r_ovf;
  logic [BW-1:0] r_bcd;
  logic [7*DIGITS-1:0] r_hex;
  logic          r_neg_out, r_ovf_out;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|w_pulse) w_next = S_CALC;
      S_CALC:  w_next = S_CONV;
      S_CONV:  if (r_iter == ITER_LAST) w_next = S_LOAD;
      S_LOAD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  logic [MW-1:0] w_a_ext, w_b_ext, w_mag;
  logic          w_neg, w_ovf;

  assign w_a_ext = MW'(r_a);
  assign w_b_ext = MW'(r_b);

  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    case (r_op)
      OP_ADD: w_mag = w_a_ext + w_b_ext;
      OP_SUB: begin
        if (r_b > r_a) begin
          w_mag = w_b_ext - w_a_ext;
          w_neg = 1'b1;
        end else begin
          w_mag = w_a_ext - w_b_ext;
        end
      end
      OP_MUL:  w_mag = w_a_ext * w_b_ext;
      default: w_mag = '0;
    endcase
    w_ovf = w_neg ? (64'(w_mag) > MAX_NEG) : (64'(w_mag) > MAX_POS);
  end

  // Double dabble step: add 3 to every nibble >= 5 before the shift.
  logic [BW-1:0] w_bcd_adj;
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  logic [7*DIGITS-1:0] w_hex;
  int                  w_msd;
  always_comb begin
    w_hex = '0;
    w_msd = 0;
    for (int i = 1; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (r_ovf)                       w_hex[7*i +: 7] = SEG_DASH;
      else if (i <= w_msd)             w_hex[7*i +: 7] = seg7(r_bcd[4*i +: 4]);
      else if (r_neg && i == w_msd + 1) w_hex[7*i +: 7] = SEG_DASH;
      else                             w_hex[7*i +: 7] = SEG_BLANK;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      r_mag     <= '0;
      r_iter    <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
      r_hex     <= HEX_RST;
      r_neg_out <= 1'b0;
      r_ovf_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_pulse) begin
            r_a  <= SW[W-1:0];
            r_b  <= SW[2*W-1:W];
            r_op <= w_op;
          end
        end
        S_CALC: begin
          r_mag  <= w_mag;
          r_neg  <= w_neg;
          r_ovf  <= w_ovf;
          r_bcd  <= '0;
          r_iter <= '0;
        end
        S_CONV: begin
          r_bcd  <= {w_bcd_adj[BW-2:0], r_mag[MW-1]};
          r_mag  <= {r_mag[MW-2:0], 1'b0};
          r_iter <= r_iter + MW'(1);
        end
        S_LOAD: begin
          r_hex     <= w_hex;
          r_neg_out <= r_neg;
          r_ovf_out <= r_ovf;
        end
        default: ;
      endcase
    end
  end

  assign HEX  = r_hex;
  assign LEDR = {r_neg_out, r_ovf_out, (r_state != S_IDLE)};

endmodule

// File: doc/kalkulator_seq.md
# kalkulator_seq

Sequential, parametrised successor to the board calculator. It synchronises and debounces the three operation keys, then latches operands A and B from SW on a key press and computes A+B, |A−B| with sign, or A·B. The result goes through an iterative double-dabble binary-to-BCD converter, and the block drives DIGITS active-low seven-segment displays with leading-zero blanking, a minus sign and an overflow indication. It sits directly between the board pins (SW/KEY/HEX/LEDR) and replaces the combinational calculator top.

## Interface
- W, 5: operand width. A = SW[W-1:0], B = SW[2W-1:W].
- DIGITS, 4: number of seven-segment digits driven; must be ≥ 2.
- DEB_CYCLES, 500000: number of consecutive stable cycles required to accept a key level change. Use 4 in simulation.
- CLOCK_50  in  1  system clock; every register is clocked on its rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- KEY  in  3  operation keys, active-low, asynchronous to the clock. KEY[0] = add, KEY[1] = subtract, KEY[2] = multiply.
- SW  in  2W  operands, sampled only in the cycle a press is accepted.
- HEX  out  7·DIGITS  segments, active-low. Digit i occupies HEX[7i+6:7i], with bit order g..a.
- LEDR  out  3  status flags: [0] busy, [1] overflow, [2] negative.

## Operation
- Key path, per key:
  - 2-FF synchroniser.
  - Debounce counter: resets whenever the synchronised level equals the debounced level. When it reaches DEB_CYCLES−1 with the level still different, the debounced level toggles.
  - Press pulse: one cycle high on a debounced 1→0 transition. A held key produces exactly one pulse.
- Simultaneous pulses in the same cycle: priority is KEY[0] > KEY[1] > KEY[2]. The lower-priority pulses are discarded.
- FSM states: IDLE → CALC → CONV → LOAD → IDLE.
  - IDLE: on any accepted pulse, latch A, B and op; go to CALC.
  - CALC: compute a 2W-bit magnitude M.
    - Add: M = A+B.
    - Subtract: M = |A−B|; neg = (B > A). A == B gives 0 with neg = 0.
    - Multiply: M = A·B.
    - Overflow check: ovf = M > 10^DIGITS−1 when neg = 0, or M > 10^(DIGITS−1)−1 when neg = 1.
    - Go to CONV.
  - CONV: exactly 2W iterations of double dabble (add-3 to each BCD nibble ≥ 5, then shift in the next MSB of M). The BCD register is DIGITS·4 bits. A 2W-bit counter ends the state.
  - LOAD: update the display and status registers; go to IDLE.
- Press pulses that arrive in CALC, CONV or LOAD are ignored. They are not queued.
- Display encoding from the BCD digits d[i]:
  - ovf = 1: every digit shows dash (0111111).
  - Otherwise, digits above the most significant non-zero digit are blank (1111111). Digit 0 is always shown, so 0 displays as "0".
  - neg = 1: the digit immediately left of the most significant digit shows dash.
  - Digit codes: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- HEX and LEDR[2:1] hold the last result until the next LOAD.

## Timing
- Reset values, effective immediately on RST_N low, including mid-CONV:
  - FSM in IDLE.
  - Debounced levels = 1, counters = 0.
  - HEX digit 0 = 1000000, all other digits = 1111111.
  - LEDR = 000.
  - Any conversion in progress is abandoned.
- Key latency: from a raw KEY fall (stable thereafter) to the press pulse is 2 + DEB_CYCLES cycles. Bounces shorter than DEB_CYCLES cycles produce no pulse.
- Compute latency: with the pulse in cycle t, operands are latched at the end of t.
  - CALC occupies t+1.
  - CONV occupies t+2 .. t+2W+1.
  - LOAD occupies t+2W+2.
  - HEX and LEDR[2:1] are new from cycle t+2W+3.
- LEDR[0] is high in cycles t+1 .. t+2W+2 and low otherwise.
- SW changes after cycle t do not affect the result in flight.

## Test plan
Defaults unless stated: W=5, DIGITS=4, DEB_CYCLES=4. Latency below is counted from the press pulse.

1. **Reset.** Assert RST_N low → HEX0 = 1000000, HEX1..HEX3 = 1111111, LEDR = 000. Then release RST_N and wait 20 cycles → all outputs unchanged.
2. **Add.** A=13, B=7 (SW = 0011101101), press KEY[0] → after 13 cycles: HEX1 = 0100100, HEX0 = 1000000, HEX2 = HEX3 = blank, LEDR = 000. LEDR[0] is high for exactly 12 cycles.
3. **Subtract, negative result.** A=3, B=20, press KEY[1] → HEX2 = dash, HEX1 = 1111001, HEX0 = 1111000 ("-17"), HEX3 = blank, LEDR[2] = 1. Then A=B=9 → shows "0" with LEDR[2] = 0.
4. **Multiply.** A=31, B=31, press KEY[2] → "961": HEX2 = 0010000, HEX1 = 0000010, HEX0 = 1111001, HEX3 = blank. With W=7 instead: A=B=127 → all four digits dash, LEDR[1] = 1.
5. **Contention.**
   - Press KEY[0] and KEY[2] in the same cycle with A=6, B=5 → "11".
   - Press KEY[1] during CONV → ignored, result stays "11".
   - Hold KEY[0] for 100 cycles → a single computation.
   - Bounce KEY[0] for 3 cycles → no pulse.
6. **Reset mid-operation.** Assert RST_N in the 5th CONV cycle → reset values immediately. After release, the next KEY[0] press computes correctly from the current SW.
